mem_access_monitor: RTL and testbench
=====================================

Name: mem_access_monitor

Overview:
- Synthesizable, parametrised memory-access checker on the core's data-side request (mem_addr/mem_done path in soc_top).
- Classifies each completed access against NUM_REGIONS address windows with per-region read/write permission.
- Keeps per-region load/store counters and captures the first faulting access (PC, address, cause).
- Raises a sticky fault plus a one-cycle interrupt pulse, so traps such as led_trap work in silicon rather than only in simulation.

Parameters:
- NUM_REGIONS, 3, number of address windows (1..8).
- ADDR_W, 32, address and PC width.
- CNT_W, 16, width of each access counter and of the fault counter.
- REGION_BASE, {32'h0100_0000, 32'h0010_0000, 32'h0}, packed NUM_REGIONS*ADDR_W base addresses; region i occupies slice i.
- REGION_LEN, {32'h10, 32'h10000, 32'h10000}, packed NUM_REGIONS*ADDR_W lengths in bytes; 0 disables the region.
- REGION_PERM, {2'b11, 2'b11, 2'b00}, packed NUM_REGIONS*2; bit0 = read allowed, bit1 = write allowed.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- en_i  in  1  monitor enable
- clear_i  in  1  clears counters, fault state and captures
- req_valid_i  in  1  access completes this cycle (mem_done)
- req_addr_i  in  ADDR_W  byte address
- req_pc_i  in  ADDR_W  PC of the accessing instruction
- req_rmask_i  in  4  load byte strobes
- req_wmask_i  in  4  store byte strobes
- load_cnt_o  out  NUM_REGIONS*CNT_W  per-region load counts
- store_cnt_o  out  NUM_REGIONS*CNT_W  per-region store counts
- fault_o  out  1  sticky fault flag
- fault_irq_o  out  1  one-cycle pulse on entry to FAULT
- fault_cause_o  out  3  captured cause code
- fault_addr_o  out  ADDR_W  captured address
- fault_pc_o  out  ADDR_W  captured PC
- fault_region_o  out  3  captured matching region, 7 when unmapped
- fault_cnt_o  out  CNT_W  total faulting accesses, saturating

Behaviour:
- Reset (async, rst_i=1): every output is 0, except fault_region_o = 7. State = IDLE.
- States:
  - IDLE: en_i=0, requests ignored. Goes to MONITOR on en_i=1.
  - MONITOR: on the first fault, go to FAULT and pulse fault_irq_o in the following cycle.
  - FAULT: keep counting; captures frozen.
  - Any state returns to IDLE when en_i=0, and outputs hold their values.
- Region match: base <= addr < base+len.
  - Evaluate base+len in ADDR_W+1 bits so windows ending at 2^ADDR_W do not wrap.
  - Overlapping windows: the lowest index wins.
- Classification applies only when req_valid_i=1 and state != IDLE. Cause codes:
  - 0: no fault.
  - 1: unmapped address.
  - 2: read to a region without read permission.
  - 3: write to a region without write permission.
  - 4: malformed request, i.e. both masks nonzero or both masks zero.
  - Priority 4 > 1 > 2/3.
- Non-faulting access: increments load_cnt (rmask!=0) or store_cnt (wmask!=0) of the matched region.
- Faulting access:
  - Increments fault_cnt_o only.
  - Captures cause, addr, pc and region only if fault_o was 0 (first-fault capture).
  - fault_o rises in the cycle after the access.
- Timing: one register stage. All outputs update on the clock edge after req_valid_i is sampled, so latency is 1 cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_i=1 has priority over a simultaneous request:
  - Counters, fault_o, captures and fault_cnt go to their reset values.
  - The same-cycle request is discarded.
  - State becomes MONITOR if en_i=1, otherwise IDLE.
- fault_irq_o fires exactly once per FAULT entry; a later fault while in FAULT does not pulse it.
- Reset asserted mid-operation: immediate return to the reset state; no partial capture survives.

Test Plan:
- Default params, en_i=1, load addr 0x0010_0004 rmask=4'hF, then store addr 0x0100_0000 wmask=4'h1 -> load_cnt[1]=1, store_cnt[2]=1, fault_o=0, fault_irq_o never asserted.
- Load addr 0x0000_0100 (region 0, perm 00) at pc 0x2d54 -> next cycle fault_o=1, cause=2, region=0, addr=0x100, pc=0x2d54, fault_irq_o high exactly 1 cycle, fault_cnt=1.
- Store to 0x0200_0000 after the previous fault -> fault_cnt=2, captures unchanged (cause 2, pc 0x2d54), no second irq.
- CNT_W=4, 20 loads to DMEM -> load_cnt[1] holds 15. Assert clear_i together with a load -> all counts 0, fault_o=0, the load is not counted.
- Region with base 0xFFFF_FFF0, len 0x10; access at 0xFFFF_FFFC allowed and counted; access at 0x0 with region 0 disabled (len 0) -> cause 1, region 7.
- Request with rmask=4'h3 and wmask=4'h3 -> cause 4. en_i=0 with requests -> no counter changes. rst_i asserted mid-FAULT -> all outputs 0 and region 7 asynchronously.

Source files
------------

// File: rtl/mem_access_monitor_if.sv
// Data-side memory request bus seen by mem_access_monitor: one beat per completed access.
interface mem_access_monitor_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [ADDR_W-1:0] req_pc_i;
    logic [3:0]        req_rmask_i;
    logic [3:0]        req_wmask_i;

    modport master (
        output req_valid_i, req_addr_i, req_pc_i, req_rmask_i, req_wmask_i
    );

    modport slave (
        input req_valid_i, req_addr_i, req_pc_i, req_rmask_i, req_wmask_i
    );
endinterface

// File: rtl/mem_access_monitor.sv
// Region-based access checker: per-region load/store counters, first-fault capture,
// sticky fault flag and a one-shot interrupt on each entry into the fault state.
module mem_access_monitor #(
    parameter int NUM_REGIONS = 3,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h0100_0000, 32'h0010_0000, 32'h0},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LEN  = {32'h10, 32'h10000, 32'h10000},
    parameter logic [NUM_REGIONS*2-1:0]      REGION_PERM = {2'b11, 2'b11, 2'b00}
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    mem_access_monitor_if.slave          req,
    output logic [NUM_REGIONS*CNT_W-1:0] load_cnt_o,
    output logic [NUM_REGIONS*CNT_W-1:0] store_cnt_o,
    output logic                         fault_o,
    output logic                         fault_irq_o,
    output logic [2:0]                   fault_cause_o,
    output logic [ADDR_W-1:0]            fault_addr_o,
    output logic [ADDR_W-1:0]            fault_pc_o,
    output logic [2:0]                   fault_region_o,
    output logic [CNT_W-1:0]             fault_cnt_o
);

    typedef enum logic [1:0] {IDLE, MONITOR, FAULT} state_t;

    localparam logic [2:0] CAUSE_NONE      = 3'd0;
    localparam logic [2:0] CAUSE_UNMAPPED  = 3'd1;
    localparam logic [2:0] CAUSE_NO_READ   = 3'd2;
    localparam logic [2:0] CAUSE_NO_WRITE  = 3'd3;
    localparam logic [2:0] CAUSE_MALFORMED = 3'd4;
    localparam logic [2:0] REGION_NONE     = 3'd7;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t state_q, state_d;

    logic [NUM_REGIONS-1:0] sel_p0;
    logic                   hit_p0;
    logic [2:0]             hit_idx_p0;
    logic [1:0]             perm_p0;
    logic                   rd_p0, wr_p0;
    logic                   active_p0, fault_hit_p0, ok_p0;
    logic [2:0]             cause_p0;

    logic [NUM_REGIONS-1:0][CNT_W-1:0] load_p1, store_p1;
    logic                   fault_p1, irq_p1;
    logic [2:0]             cause_p1, region_p1;
    logic [ADDR_W-1:0]      addr_p1, pc_p1;
    logic [CNT_W-1:0]       fault_cnt_p1;

    // Stage p0: region decode and classification of the current request.
    always_comb begin
        logic [ADDR_W-1:0] base, len;
        logic [ADDR_W:0]   lim;
        sel_p0     = '0;
        hit_p0     = 1'b0;
        hit_idx_p0 = REGION_NONE;
        perm_p0    = 2'b00;
        base       = '0;
        len        = '0;
        lim        = '0;
        // Scan downward so the lowest matching index is the one that sticks.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            base = REGION_BASE[i*ADDR_W +: ADDR_W];
            len  = REGION_LEN[i*ADDR_W +: ADDR_W];
            lim  = {1'b0, base} + {1'b0, len};
            if (len != '0 && req.req_addr_i >= base && {1'b0, req.req_addr_i} < lim) begin
                sel_p0     = '0;
                sel_p0[i]  = 1'b1;
                hit_p0     = 1'b1;
                hit_idx_p0 = 3'(i);
                perm_p0    = REGION_PERM[i*2 +: 2];
            end
        end
    end

    always_comb begin
        rd_p0     = |req.req_rmask_i;
        wr_p0     = |req.req_wmask_i;
        active_p0 = req.req_valid_i && (state_q != IDLE);
        if (rd_p0 == wr_p0)          cause_p0 = CAUSE_MALFORMED;
        else if (!hit_p0)            cause_p0 = CAUSE_UNMAPPED;
        else if (rd_p0 && !perm_p0[0]) cause_p0 = CAUSE_NO_READ;
        else if (wr_p0 && !perm_p0[1]) cause_p0 = CAUSE_NO_WRITE;
        else                         cause_p0 = CAUSE_NONE;
        fault_hit_p0 = active_p0 && (cause_p0 != CAUSE_NONE);
        ok_p0        = active_p0 && (cause_p0 == CAUSE_NONE);
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = en_i ? MONITOR : IDLE;
        end else if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = MONITOR;
                MONITOR: if (fault_hit_p0) state_d = FAULT;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Stage p1: counters, sticky fault and first-fault capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            load_p1      <= '0;
            store_p1     <= '0;
            fault_p1     <= 1'b0;
            irq_p1       <= 1'b0;
            cause_p1     <= CAUSE_NONE;
            region_p1    <= REGION_NONE;
            addr_p1      <= '0;
            pc_p1        <= '0;
            fault_cnt_p1 <= '0;
        end else begin
            irq_p1 <= fault_hit_p0 && (state_q == MONITOR);
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (ok_p0 && sel_p0[i] && rd_p0) load_p1[i]  <= sat_inc(load_p1[i]);
                if (ok_p0 && sel_p0[i] && wr_p0) store_p1[i] <= sat_inc(store_p1[i]);
            end
            if (fault_hit_p0) begin
                fault_p1     <= 1'b1;
                fault_cnt_p1 <= sat_inc(fault_cnt_p1);
                if (!fault_p1) begin
                    cause_p1  <= cause_p0;
                    region_p1 <= hit_idx_p0;
                    addr_p1   <= req.req_addr_i;
                    pc_p1     <= req.req_pc_i;
                end
            end
        end
    end

    assign load_cnt_o     = load_p1;
    assign store_cnt_o    = store_p1;
    assign fault_o        = fault_p1;
    assign fault_irq_o    = irq_p1;
    assign fault_cause_o  = cause_p1;
    assign fault_addr_o   = addr_p1;
    assign fault_pc_o     = pc_p1;
    assign fault_region_o = region_p1;
    assign fault_cnt_o    = fault_cnt_p1;

endmodule

// File: tb/tb_mem_access_monitor.sv
// Directed bench for mem_access_monitor: default map (dut A) and a CNT_W=4 top-of-memory map (dut B).
module tb_mem_access_monitor;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int CA = 16;
    localparam int CB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0, clr_a = 1'b0, en_b = 1'b0, clr_b = 1'b0;

    always #5 clk = ~clk;

    mem_access_monitor_if #(.ADDR_W(AW)) if_a ();
    mem_access_monitor_if #(.ADDR_W(AW)) if_b ();

    logic [NR*CA-1:0] load_a, store_a;
    logic [NR*CB-1:0] load_b, store_b;
    logic             fault_a, irq_a, fault_b, irq_b;
    logic [2:0]       cause_a, region_a, cause_b, region_b;
    logic [AW-1:0]    faddr_a, fpc_a, faddr_b, fpc_b;
    logic [CA-1:0]    fcnt_a;
    logic [CB-1:0]    fcnt_b;

    mem_access_monitor dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en_a), .clear_i(clr_a), .req(if_a.slave),
        .load_cnt_o(load_a), .store_cnt_o(store_a), .fault_o(fault_a), .fault_irq_o(irq_a),
        .fault_cause_o(cause_a), .fault_addr_o(faddr_a), .fault_pc_o(fpc_a),
        .fault_region_o(region_a), .fault_cnt_o(fcnt_a)
    );

    mem_access_monitor #(
        .CNT_W(CB),
        .REGION_BASE({32'hFFFF_FFF0, 32'h0010_0000, 32'h0}),
        .REGION_LEN ({32'h10, 32'h10000, 32'h0})
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .clear_i(clr_b), .req(if_b.slave),
        .load_cnt_o(load_b), .store_cnt_o(store_b), .fault_o(fault_b), .fault_irq_o(irq_b),
        .fault_cause_o(cause_b), .fault_addr_o(faddr_b), .fault_pc_o(fpc_b),
        .fault_region_o(region_b), .fault_cnt_o(fcnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int irq_cnt_a = 0;

    always @(posedge clk) if (irq_a) irq_cnt_a++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        if_a.req_valid_i = 1'b0; if_a.req_rmask_i = 4'h0; if_a.req_wmask_i = 4'h0;
        if_b.req_valid_i = 1'b0; if_b.req_rmask_i = 4'h0; if_b.req_wmask_i = 4'h0;
    endtask

    // Drives one access at the current negedge and returns at the next negedge.
    task automatic acc(input bit sel_b, input logic [31:0] addr, input logic [31:0] pc,
                       input logic [3:0] rm, input logic [3:0] wm);
        if (sel_b) begin
            if_b.req_valid_i = 1'b1; if_b.req_addr_i = addr; if_b.req_pc_i = pc;
            if_b.req_rmask_i = rm;   if_b.req_wmask_i = wm;
        end else begin
            if_a.req_valid_i = 1'b1; if_a.req_addr_i = addr; if_a.req_pc_i = pc;
            if_a.req_rmask_i = rm;   if_a.req_wmask_i = wm;
        end
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.req_addr_i = '0; if_a.req_pc_i = '0;
        if_b.req_addr_i = '0; if_b.req_pc_i = '0;
        idle_bus();
        repeat (2) @(negedge clk);
        check("rst_region", 64'(region_a), 64'd7);
        check("rst_fault", 64'(fault_a), 64'd0);
        check("rst_load", 64'(load_a), 64'd0);
        check("rst_fcnt", 64'(fcnt_a), 64'd0);
        rst = 1'b0;
        en_a = 1'b1;
        @(negedge clk);

        // Legal load and store.
        acc(0, 32'h0010_0004, 32'h1000, 4'hF, 4'h0);
        acc(0, 32'h0100_0000, 32'h1004, 4'h0, 4'h1);
        check("load_cnt1", 64'(load_a[CA*1 +: CA]), 64'd1);
        check("store_cnt2", 64'(store_a[CA*2 +: CA]), 64'd1);
        check("no_fault", 64'(fault_a), 64'd0);
        check("no_irq", 64'(irq_cnt_a), 64'd0);

        // Read from a no-permission region.
        acc(0, 32'h0000_0100, 32'h2d54, 4'hF, 4'h0);
        check("f1_fault", 64'(fault_a), 64'd1);
        check("f1_irq", 64'(irq_a), 64'd1);
        check("f1_cause", 64'(cause_a), 64'd2);
        check("f1_region", 64'(region_a), 64'd0);
        check("f1_addr", 64'(faddr_a), 64'h100);
        check("f1_pc", 64'(fpc_a), 64'h2d54);
        check("f1_fcnt", 64'(fcnt_a), 64'd1);
        @(negedge clk);
        check("f1_irq_drop", 64'(irq_a), 64'd0);
        check("f1_irq_once", 64'(irq_cnt_a), 64'd1);

        // Second fault while already faulted.
        acc(0, 32'h0200_0000, 32'h3000, 4'h0, 4'hF);
        check("f2_fcnt", 64'(fcnt_a), 64'd2);
        check("f2_cause", 64'(cause_a), 64'd2);
        check("f2_pc", 64'(fpc_a), 64'h2d54);
        @(negedge clk);
        check("f2_no_irq", 64'(irq_cnt_a), 64'd1);

        // Clear, then a malformed request.
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check("clr_fault", 64'(fault_a), 64'd0);
        check("clr_load", 64'(load_a), 64'd0);
        acc(0, 32'h0010_0000, 32'h4000, 4'h3, 4'h3);
        check("mal_cause", 64'(cause_a), 64'd4);
        check("mal_region", 64'(region_a), 64'd1);
        check("mal_fcnt", 64'(fcnt_a), 64'd1);
        @(negedge clk);
        check("mal_irq", 64'(irq_cnt_a), 64'd2);

        // Disabled monitor ignores traffic and holds outputs.
        en_a = 1'b0;
        @(negedge clk);
        acc(0, 32'h0010_0004, 32'h5000, 4'hF, 4'h0);
        acc(0, 32'h0200_0000, 32'h5004, 4'hF, 4'h0);
        check("dis_load", 64'(load_a[CA*1 +: CA]), 64'd0);
        check("dis_fcnt", 64'(fcnt_a), 64'd1);
        check("dis_hold", 64'(fault_a), 64'd1);

        // Re-enter FAULT then reset asynchronously mid-cycle.
        en_a = 1'b1;
        @(negedge clk);
        acc(0, 32'h0000_0100, 32'h6000, 4'hF, 4'h0);
        check("re_fcnt", 64'(fcnt_a), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_fault", 64'(fault_a), 64'd0);
        check("arst_region", 64'(region_a), 64'd7);
        check("arst_fcnt", 64'(fcnt_a), 64'd0);
        check("arst_addr", 64'(faddr_a), 64'd0);
        check("arst_cause", 64'(cause_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        en_a = 1'b0;
        en_b = 1'b1;
        @(negedge clk);

        // Saturation with CNT_W=4.
        for (int k = 0; k < 20; k++) acc(1, 32'h0010_0000, 32'h7000, 4'hF, 4'h0);
        check("sat_load", 64'(load_b[CB*1 +: CB]), 64'd15);
        acc(1, 32'h0200_0000, 32'h7100, 4'h0, 4'hF);
        check("b_fault", 64'(fault_b), 64'd1);

        // Clear wins over a simultaneous load.
        clr_b = 1'b1;
        acc(1, 32'h0010_0000, 32'h7200, 4'hF, 4'h0);
        clr_b = 1'b0;
        check("clr_b_load", 64'(load_b), 64'd0);
        check("clr_b_fault", 64'(fault_b), 64'd0);
        check("clr_b_fcnt", 64'(fcnt_b), 64'd0);

        // Window ending at the top of the address space.
        acc(1, 32'hFFFF_FFFC, 32'h7300, 4'hF, 4'h0);
        check("top_load", 64'(load_b[CB*2 +: CB]), 64'd1);
        check("top_nofault", 64'(fault_b), 64'd0);

        // Address 0 with region 0 disabled.
        acc(1, 32'h0000_0000, 32'h7400, 4'hF, 4'h0);
        check("unm_cause", 64'(cause_b), 64'd1);
        check("unm_region", 64'(region_b), 64'd7);
        check("unm_pc", 64'(fpc_b), 64'h7400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
